// File: rtl/multdiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit and its decode.
// No logic; state encodings, ALU opcodes and the default datapath width.
package multdiv_pkg;

    localparam int MULTDIV_WIDTH = 32;

    // Decode turns these ALU opcodes into the ctrl_MULT / ctrl_DIV start pulses.
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, emit quotient bit.
// Purely combinational; no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // rem_in < divisor, so the kept remainder always fits back into WIDTH bits.
    assign rem_out = WIDTH'(q_bit ? diff : shifted);

endmodule

// File: rtl/multdiv_unit.sv
// Signed multi-cycle multiply (radix-2 Booth) / divide (restoring) for the execute stage.
// Latency: result strobe in the cycle after edge WIDTH+1 from the start edge.
// No backpressure: the pipeline stalls on busy; any new start aborts and restarts.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULTDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               div_zero;
    logic               div_ovf;

    logic [WIDTH:0]     booth_acc;
    logic [WIDTH:0]     booth_mc;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;
    logic               last_iter;

    // Accumulate in WIDTH+1 bits so subtracting the most negative multiplicand
    // cannot wrap before the arithmetic shift picks up the sign.
    assign booth_acc = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    assign booth_mc  = {mcand[WIDTH-1], mcand};

    always_comb begin
        booth_sum = booth_acc;
        case (prod[1:0])
            2'b01:   booth_sum = booth_acc + booth_mc;
            2'b10:   booth_sum = booth_acc - booth_mc;
            default: booth_sum = booth_acc;
        endcase
    end

    assign product   = prod[2*WIDTH:1];
    assign mul_ovf   = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
    assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign last_iter = (cnt == CNT_W'(WIDTH));

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem),
        .dividend_bit (quo[WIDTH-1]),
        .divisor      (divisor),
        .rem_out      (rem_nxt),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            prod           <= '0;
            mcand          <= '0;
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            cnt            <= '0;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                state <= MUL;
                prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                mcand <= data_operandA;
            end else begin
                state    <= DIV;
                rem      <= '0;
                quo      <= a_mag;
                divisor  <= b_mag;
                neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (data_operandB == {WIDTH{1'b1}});
            end
        end else begin
            case (state)
                MUL: begin
                    if (last_iter) begin
                        data_result    <= product[WIDTH-1:0];
                        data_exception <= mul_ovf;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        prod <= {booth_sum, prod[WIDTH:1]};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (last_iter) begin
                        if (div_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else if (div_ovf) begin
                            data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= neg_q ? -quo : quo;
                            data_exception <= 1'b0;
                        end
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed mul/div vectors, abort, async reset.
module tb_multdiv_unit;

    localparam int LAT = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        x;
    } vec_t;

    vec_t vecs[8];

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_strobe: got result %h with no pending op", data_result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
                chk("latency_edge", edge_cnt, e.due);
                chk("busy_at_strobe", {31'b0, busy}, 32'd0);
                last_res = e.res;
            end
        end
    end

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] r, input logic x);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        if (push) begin
            e.res = r;
            e.exc = x;
            e.due = edge_cnt + 1 + LAT;
            sbq.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending, want 0", sbq.size());
            sbq.delete();
        end
        @(negedge clock);
        chk("rdy_one_cycle", {31'b0, data_resultRDY}, 32'd0);
        chk("result_hold", data_result, last_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd100,       32'd0,         32'h0000_0000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};

        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r, vecs[i].x);
            wait_done();
        end

        // Abort: a DIV start 10 edges into a MUL replaces it; only the DIV strobes.
        issue(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0);
        repeat (8) @(negedge clock);
        issue(1'b0, 1'b1, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);
        wait_done();

        // Both start pulses together: multiply takes priority.
        issue(1'b1, 1'b1, 32'd4, 32'd2, 1'b1, 32'd8, 1'b0);
        wait_done();

        // Async reset between edges in the middle of a divide.
        issue(1'b0, 1'b1, 32'd1000, 32'd7, 1'b0, 32'd0, 1'b0);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_result", data_result, 32'd0);
        chk("async_rst_exc", {31'b0, data_exception}, 32'd0);
        chk("async_rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        #1 reset = 1'b0;
        last_res = '0;
        repeat (45) @(negedge clock);
        chk("post_rst_result", data_result, 32'd0);

        issue(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiplier/divider used by the processor's execute stage for the mul and div ALU ops.
- Execute stage issues a one-cycle start pulse with operands, then stalls the pipeline.
- Unit returns the result with a one-cycle ready strobe and an exception flag; the processor writes the result back to the regfile and sets rstatus on exception.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  master clock, rising-edge active
reset  input  1  asynchronous, active-high reset
data_operandA  input  WIDTH  multiplicand / dividend, sampled only on the start edge
data_operandB  input  WIDTH  multiplier / divisor, sampled only on the start edge
ctrl_MULT  input  1  one-cycle start pulse for signed multiply
ctrl_DIV  input  1  one-cycle start pulse for signed divide
data_result  output  WIDTH  low WIDTH bits of the product, or the quotient
data_exception  output  1  overflow or divide error; qualified by data_resultRDY
data_resultRDY  output  1  one-cycle strobe: result is valid
busy  output  1  high from the cycle after a start edge until the cycle data_resultRDY is high

Behaviour:
- Reset: state=IDLE, counter=0, internal regs=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. Takes effect immediately, in any state.
- States: IDLE, MUL, DIV, DONE.
- Start edge: a rising edge at which ctrl_MULT or ctrl_DIV is 1.
  - Operands are latched; counter is cleared.
  - Go to MUL (if ctrl_MULT) or DIV.
  - If both are 1 on the same edge, ctrl_MULT wins.
- A start edge in any state (including MUL, DIV or DONE) aborts the current operation and restarts. No strobe is produced for the aborted operation.
- MUL:
  - Radix-2 Booth iteration, one per edge.
  - 2*WIDTH+1-bit product register; arithmetic right shift.
  - After WIDTH iterations, go to DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per edge.
  - Operand signs are recorded at the start edge.
  - After WIDTH iterations, go to DONE.
  - The quotient is negated if the operand signs differ, so the quotient truncates toward zero. The remainder is discarded.
- Latency: data_resultRDY is high during the cycle following edge number WIDTH+1 counted from the start edge (start edge = 0). This is identical for MUL and DIV, including the exception cases.
- DONE: lasts exactly one cycle with data_resultRDY=1, then IDLE with data_resultRDY=0.
- data_result and data_exception hold their values until the next start edge or reset.
- MUL exception: set when the full 2*WIDTH-bit signed product is not the sign extension of its low WIDTH bits. data_result is still the low WIDTH bits.
- DIV by zero: data_result=0, data_exception=1.
- DIV of 0x80000000 by -1: data_result=0x80000000, data_exception=1.
- Otherwise data_exception=0.
- ctrl_MULT/ctrl_DIV held high for multiple cycles: every such edge is a start edge. Callers must pulse for exactly one cycle.

Decomposition:
- Package multdiv_pkg holds:
  - state encodings (IDLE=2'b00, MUL=2'b01, DIV=2'b10, DONE=2'b11);
  - ALU opcode constants OP_MUL=5'b00110 and OP_DIV=5'b00111, used by the processor decode to generate the start pulses;
  - WIDTH default.
- One sub-module, div_step: combinational single iteration of restoring division (remainder shift, trial subtract, quotient bit). It is instantiated once.
- Booth step stays inline.

Test Plan:
1. MULT pulse with A=7, B=-3. data_resultRDY high exactly one cycle, 33 edges after start; data_result=0xFFFFFFEB, exception=0; busy low in that cycle.
2. MULT with A=0x00010000, B=0x00010000: result=0x00000000, exception=1. MULT with A=0x80000000, B=1: result=0x80000000, exception=0.
3. DIV with A=-7, B=2: result=0xFFFFFFFD (-3), exception=0. DIV with A=100, B=0: result=0, exception=1 at the same latency.
4. DIV with A=0x80000000, B=0xFFFFFFFF: result=0x80000000, exception=1.
5. MULT start (A=5, B=5), then at edge 10 a DIV start (A=9, B=3): exactly one strobe, 33 edges after the second start, with result=3. ctrl_MULT and ctrl_DIV pulsed together with A=4, B=2: result=8.
6. Assert reset asynchronously mid-DIV, between edges: outputs go to 0 immediately with no clock. After release, no strobe appears; a new MULT (A=6, B=7) completes normally with result=42.
